// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART transmitter between NUM_REQ byte sources.
// Round-robin per byte, optional lock to keep ownership across a multi-byte
// message, and a watchdog that abandons a byte whose Done never arrives.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int CLKS_PER_BIT = 217,
  parameter int TIMEOUT_CLKS = 11*CLKS_PER_BIT+16
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [NUM_REQ-1:0]   i_Lock,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Ack,
  output logic [NUM_REQ-1:0]   o_Done,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Busy,
  output logic                 o_Timeout,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CLKS+1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CLKS-1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ-1);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

  state_t                        state;
  logic [IDX_W-1:0]              ptr;
  logic [IDX_W-1:0]              owner;
  logic [WD_W-1:0]               wdog;
  logic [IDX_W-1:0]              winner;
  logic [IDX_W-1:0]              cand;
  logic                          win_vld;
  logic [NUM_REQ-1:0]            win_onehot;
  logic [NUM_REQ-1:0][7:0]       req_bytes;

  assign req_bytes = i_Req_Byte;

  // Round-robin search: first requesting index after the pointer, wrapping.
  always_comb begin
    winner  = '0;
    cand    = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr) + i >= NUM_REQ) ? IDX_W'(int'(ptr) + i - NUM_REQ)
                                        : IDX_W'(int'(ptr) + i);
      if (!win_vld && i_Req[cand]) begin
        winner  = cand;
        win_vld = 1'b1;
      end
    end
    win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
  end

  // Ownership FSM: launch, wait for Done (or watchdog), optional locked relaunch, one-cycle gap.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state     <= IDLE;
      ptr       <= PTR_RST;
      owner     <= '0;
      wdog      <= '0;
      o_Ack     <= '0;
      o_Done    <= '0;
      o_Grant   <= '0;
      o_Busy    <= 1'b0;
      o_Timeout <= 1'b0;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= '0;
    end else begin
      // pulse outputs default low every cycle
      o_Ack     <= '0;
      o_Done    <= '0;
      o_Timeout <= 1'b0;
      o_TX_DV   <= 1'b0;
      case (state)
        IDLE: begin
          // never launch over a frame the transmitter still owns
          if (!i_TX_Active && win_vld) begin
            owner     <= winner;
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= req_bytes[winner];
            o_Ack     <= win_onehot;
            o_Grant   <= win_onehot;
            o_Busy    <= 1'b1;
            wdog      <= '0;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // Done takes priority over a watchdog expiry in the same cycle
          if (i_TX_Done) begin
            o_Done <= o_Grant;
            ptr    <= owner;
            wdog   <= '0;
            if (i_Lock[owner] && i_Req[owner]) begin
              o_TX_DV   <= 1'b1;
              o_Ack     <= o_Grant;
              o_TX_Byte <= req_bytes[owner];
            end else begin
              o_Grant <= '0;
              o_Busy  <= 1'b0;
              state   <= GAP;
            end
          end else if (wdog == WD_LAST) begin
            o_Timeout <= 1'b1;
            ptr       <= owner;
            wdog      <= '0;
            o_Grant   <= '0;
            o_Busy    <= 1'b0;
            state     <= GAP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural 8N1 transmitter, queue-driven requesters,
// directed table, corner-case sequences and randomized messages vs a queue model.
module tb_uart_tx_arbiter;
  localparam int N   = 3;
  localparam int CPB = 4;
  localparam int TO  = 60;

  typedef struct { logic [7:0] b; logic l; } item_t;
  typedef struct { int own; logic [7:0] b; } launch_t;
  typedef struct { logic [N-1:0] mask; int exp; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]   req = '0, lock = '0;
  logic [8*N-1:0] req_byte = '0;
  logic [N-1:0]   ack, done, grant;
  logic           busy, timeout, tx_dv;
  logic [7:0]     tx_byte;
  logic           active, txd;
  logic           stub = 1'b0, stub_done = 1'b0;

  // behavioural transmitter state
  logic       m_busy = 1'b0, m_active = 1'b0, m_done = 1'b0, m_line = 1'b1;
  logic [9:0] m_frame = '0;
  int         m_cnt = 0, m_bit = 0;

  int checks = 0, failures = 0;
  int cyc = 0;
  item_t   rq [N][$];
  launch_t log_q[$];
  launch_t exp_q[$];
  int done_cnt = 0, to_cnt = 0, relaunch_cnt = 0, last_to_cyc = -1000, last_dv_cyc = 0;
  int m_ptr = N-1;
  logic [N-1:0] last_ack = '0;

  always #5 clk = ~clk;

  assign active = stub ? 1'b0 : m_active;
  assign txd    = stub ? stub_done : m_done;

  uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock(clk), .i_Rst(rst), .i_Req(req), .i_Lock(lock), .i_Req_Byte(req_byte),
    .o_Ack(ack), .o_Done(done), .o_Grant(grant), .o_Busy(busy), .o_Timeout(timeout),
    .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .i_TX_Active(active), .i_TX_Done(txd)
  );

  // 8N1 transmitter: start, 8 data LSB first, stop; Done pulses as the line goes idle
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_busy <= 1'b0; m_active <= 1'b0; m_line <= 1'b1;
    end else if (!m_busy) begin
      if (tx_dv) begin
        m_frame <= {1'b1, tx_byte, 1'b0};
        m_busy <= 1'b1; m_active <= 1'b1; m_cnt <= 0; m_bit <= 0; m_line <= 1'b0;
      end
    end else if (m_cnt == CPB-1) begin
      m_cnt <= 0;
      if (m_bit == 9) begin
        m_busy <= 1'b0; m_active <= 1'b0; m_done <= 1'b1; m_line <= 1'b1;
      end else begin
        m_bit <= m_bit + 1; m_line <= m_frame[m_bit+1];
      end
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    if ($onehot(v)) for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k]            = rq[k].size() > 0;
      lock[k]           = (rq[k].size() > 0) ? rq[k][0].l : 1'b0;
      req_byte[8*k +: 8] = (rq[k].size() > 0) ? rq[k][0].b : 8'h00;
    end
  endtask

  task automatic clear_q();
    for (int k = 0; k < N; k++) rq[k].delete();
  endtask

  // one clock: observe outputs at the falling edge, retire acked bytes, re-drive requests
  task automatic step();
    @(negedge clk);
    cyc++;
    if (|done) begin
      check("done_owner", done, last_ack);
      done_cnt++;
    end
    if (timeout) begin to_cnt++; last_to_cyc = cyc; end
    if (tx_dv) begin
      check("grant_matches_ack", grant, ack);
      log_q.push_back('{onehot_idx(ack), tx_byte});
      last_ack    = ack;
      last_dv_cyc = cyc;
      if (|done) relaunch_cnt++;
    end
    for (int k = 0; k < N; k++) if (ack[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1; stub = 1'b0; stub_done = 1'b0;
    clear_q(); drive();
    step(); step();
    rst = 1'b0;
    log_q.delete();
    done_cnt = 0; to_cnt = 0; relaunch_cnt = 0; last_ack = '0; last_to_cyc = -1000;
    m_ptr = N-1;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int q = 0;
    for (int i = 0; i < budget && q < 3; i++) begin
      step();
      if (!busy && !m_active && !(|req)) q++; else q = 0;
    end
    if (q < 3) begin
      checks++; failures++;
      $display("FAIL %s: not idle after %0d cycles", name, budget);
    end
  endtask

  task automatic wait_dv(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      step();
      if (tx_dv) return;
    end
    checks++; failures++;
    $display("FAIL %s: no launch within %0d cycles", name, budget);
  endtask

  // Reference: serve queued bytes round-robin; a locked head byte continues the owner.
  task automatic predict();
    item_t mq [N][$];
    int own = -1;
    int c;
    bit any;
    exp_q.delete();
    for (int k = 0; k < N; k++) mq[k] = rq[k];
    forever begin
      any = 0;
      for (int k = 0; k < N; k++) if (mq[k].size() > 0) any = 1;
      if (!any) break;
      if (!(own >= 0 && mq[own].size() > 0 && mq[own][0].l)) begin
        own = -1;
        for (int i = 1; i <= N && own < 0; i++) begin
          c = (m_ptr + i) % N;
          if (mq[c].size() > 0) own = c;
        end
      end
      exp_q.push_back('{own, mq[own][0].b});
      void'(mq[own].pop_front());
      m_ptr = own;
    end
  endtask

  initial begin
    vec_t vt[7];
    logic [9:0] ser;
    int lc, l2, lr, n;

    vt[0] = '{3'b111, 0}; vt[1] = '{3'b111, 1}; vt[2] = '{3'b101, 2};
    vt[3] = '{3'b110, 1}; vt[4] = '{3'b011, 0}; vt[5] = '{3'b100, 2};
    vt[6] = '{3'b010, 1};

    // reset state
    do_reset();
    check("reset_outputs", {ack, done, grant, busy, timeout, tx_dv, tx_byte}, '0);

    // single byte from requester 1
    rq[1].push_back('{8'hA5, 1'b0}); drive();
    step();
    check("single_dv_latency", tx_dv, 1);
    check("single_ack", ack, 3'b010);
    check("single_grant", grant, 3'b010);
    check("single_busy", busy, 1);
    check("single_byte", tx_byte, 8'hA5);
    step(); step();
    for (int b = 0; b < 10; b++) begin
      ser[b] = m_line;
      if (b == 5) check("single_byte_held", tx_byte, 8'hA5);
      repeat (4) step();
    end
    check("single_serial", ser, 10'b1101001010);
    wait_quiet(100, "single_quiet");
    check("single_done_count", done_cnt, 1);

    // fairness
    do_reset();
    for (int k = 0; k < N; k++) begin
      rq[k].push_back('{8'(8'h10 + k), 1'b0});
      rq[k].push_back('{8'(8'h10 + k), 1'b0});
    end
    drive();
    wait_quiet(1000, "fair_quiet");
    check("fair_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      check("fair_owner", log_q[i].own, i % 3);
      check("fair_byte", log_q[i].b, 8'h10 + i % 3);
    end
    check("fair_done_count", done_cnt, 6);

    // locked multi-byte message with a competing requester
    do_reset();
    rq[0].push_back('{8'h01, 1'b0});
    rq[0].push_back('{8'h02, 1'b1});
    rq[0].push_back('{8'h03, 1'b1});
    rq[2].push_back('{8'h12, 1'b0});
    drive();
    wait_quiet(1000, "lock_quiet");
    check("lock_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("lock_seq", {log_q[0].b, log_q[1].b, log_q[2].b, log_q[3].b}, 32'h01020312);
      check("lock_owner_last", log_q[3].own, 2);
    end
    check("lock_relaunches", relaunch_cnt, 2);
    check("lock_done_count", done_cnt, 4);

    // watchdog abort, then Done and the limit in the same clock
    do_reset();
    stub = 1'b1;
    rq[0].push_back('{8'h20, 1'b0});
    rq[0].push_back('{8'h21, 1'b0});
    rq[1].push_back('{8'h30, 1'b0});
    drive();
    wait_dv(5, "to_launch");
    lc = last_dv_cyc;
    check("to_first_ack", ack, 3'b001);
    for (int i = 0; i < 80 && !timeout; i++) step();
    check("timeout_latency", last_to_cyc - lc, TO);
    check("timeout_no_done", done_cnt, 0);
    wait_dv(10, "to_next_launch");
    l2 = last_dv_cyc;
    check("to_next_ack", ack, 3'b010);
    check("to_next_byte", tx_byte, 8'h30);
    while (cyc < l2 + TO - 1) step();
    stub_done = 1'b1;
    step();
    stub_done = 1'b0;
    check("simul_done", done, 3'b010);
    check("simul_no_timeout", timeout, 0);
    check("timeout_count", to_cnt, 1);

    // reset during data bit 3
    do_reset();
    rq[0].push_back('{8'h40, 1'b0});
    rq[1].push_back('{8'h41, 1'b0});
    drive();
    wait_dv(5, "rst_launch");
    lr = last_dv_cyc;
    while (cyc < lr + 18) step();
    rst = 1'b1; clear_q(); drive();
    step();
    check("rst_mid_outputs", {ack, done, grant, busy, timeout, tx_dv, tx_byte}, '0);
    rst = 1'b0;
    log_q.delete(); done_cnt = 0; to_cnt = 0;
    rq[1].push_back('{8'h41, 1'b0});
    rq[0].push_back('{8'h40, 1'b0});
    drive();
    wait_quiet(500, "rst_quiet");
    check("rst_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("rst_first_owner", log_q[0].own, 0);
      check("rst_seq", {log_q[0].b, log_q[1].b}, 16'h4041);
    end
    check("rst_done_count", done_cnt, 2);
    check("rst_no_timeout", to_cnt, 0);

    // arbitration table, pointer carried from vector to vector
    do_reset();
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < N; k++) if (vt[v].mask[k]) rq[k].push_back('{8'(8'h10 + k), 1'b0});
      drive();
      wait_dv(10, "tbl_launch");
      check("tbl_owner", ack, 1 << vt[v].exp);
      check("tbl_byte", tx_byte, 8'h10 + vt[v].exp);
      clear_q(); drive();
      wait_quiet(200, "tbl_quiet");
    end

    // randomized messages against the queue model
    do_reset();
    for (int r = 0; r < 4; r++) begin
      log_q.delete(); done_cnt = 0;
      for (int k = 0; k < N; k++) begin
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++)
          rq[k].push_back('{8'($urandom_range(0, 255)), 1'($urandom_range(0, 1))});
      end
      predict();
      drive();
      wait_quiet(3000, "rand_quiet");
      check("rand_count", log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
        check("rand_owner", log_q[i].own, exp_q[i].own);
        check("rand_byte", log_q[i].b, exp_q[i].b);
      end
      check("rand_done_count", done_cnt, exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
